// File: rtl/alu_pkg.sv
// Shared types and constants for the serial 74181-style ALU.
package alu_pkg;

    // Width of one 74181 slice processed per clock
    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Common 74181 select encodings (active-high data table)
    localparam logic [3:0] SelAdd = 4'b1001;  // m = 0: A plus B
    localparam logic [3:0] SelSub = 4'b0110;  // m = 0: A minus B minus 1 (cn = 0 gives A minus B)
    localparam logic [3:0] SelXor = 4'b0110;  // m = 1: A xor B
    localparam logic [3:0] SelAnd = 4'b1011;  // m = 1: A and B
    localparam logic [3:0] SelOr  = 4'b1110;  // m = 1: A or B

endpackage

// File: rtl/alu_slice.sv
// Combinational 4-bit 74181 slice, active-high data.
// Carry ports are active-low (74181 style); p/g are active-high.
// ALU_SERIAL_OVF_EN adds c_msb, the carry into the slice MSB.
module alu_slice
    import alu_pkg::*;
(
    input  logic [3:0]         s,
    input  logic               m,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cn,
    output logic [SLICE_W-1:0] f,
    output logic               cn_4,
    output logic               p,
    output logic               g
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic               c_msb
`endif
);

    logic [SLICE_W-1:0] pi;
    logic [SLICE_W-1:0] gi;
    logic [SLICE_W-1:0] hs;
    logic [SLICE_W-1:0] c;
    logic               cy;

    // Per-bit propagate/generate selected by s, ripple carry, then result
    always_comb begin
        pi = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
        gi = (a & ~b & {SLICE_W{s[2]}}) | (a & b & {SLICE_W{s[3]}});
        hs = pi & ~gi;
        // Logic mode kills the chain so carry never reaches f or cn_4
        cy = ~cn & ~m;
        c  = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            c[i] = cy;
            cy   = (gi[i] | (pi[i] & cy)) & ~m;
        end
        f    = m ? ~hs : (hs ^ c);
        cn_4 = ~cy;
        p    = &pi;
        g    = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) |
               (pi[3] & pi[2] & pi[1] & gi[0]);
    end

`ifdef ALU_SERIAL_OVF_EN
    assign c_msb = c[SLICE_W-1];
`endif

endmodule

// File: rtl/alu_serial.sv
// Multi-cycle 74181-compatible ALU: one 4-bit slice per clock, LSB first,
// with valid/ready handshakes on input and output.
// Optional feature macro: ALU_SERIAL_OVF_EN adds the ovf output.
module alu_serial
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NSLICE = WIDTH / SLICE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             cn_out,
    output logic             a_eq_b,
    output logic             p,
    output logic             g
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("alu_serial: WIDTH must be a multiple of 4 and at least 4");
    end
    if (NSLICE != WIDTH / SLICE_W) begin : g_bad_nslice
        $error("alu_serial: NSLICE is derived and must not be overridden");
    end

    state_e             state_q;
    logic [KW-1:0]      k_q;
    logic [3:0]         s_q;
    logic               m_q;
    logic               carry_q;  // active-low, as at the 74181 pins
    logic               pacc_q;
    logic               gacc_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sl_f;
    logic               sl_cn4;
    logic               sl_p;
    logic               sl_g;
    logic [WIDTH-1:0]   f_next;
    logic               pacc_next;
    logic               gacc_next;
    logic               last;
`ifdef ALU_SERIAL_OVF_EN
    logic               sl_cmsb;
`endif

    // Handshake flags decode straight from the state flops
    assign in_ready  = (state_q == StIdle) && !rst;
    assign out_valid = (state_q == StDone);

    // Select the current slice of the latched operands and merge its result
    always_comb begin
        a_sl   = '0;
        b_sl   = '0;
        f_next = f;
        for (int i = 0; i < NSLICE; i++) begin
            if (k_q == KW'(i)) begin
                a_sl = a_q[i*SLICE_W +: SLICE_W];
                b_sl = b_q[i*SLICE_W +: SLICE_W];
                f_next[i*SLICE_W +: SLICE_W] = sl_f;
            end
        end
        pacc_next = pacc_q & sl_p;
        gacc_next = sl_g | (sl_p & gacc_q);
        last      = (k_q == KW'(NSLICE - 1));
    end

    alu_slice u_slice (
        .s    (s_q),
        .m    (m_q),
        .a    (a_sl),
        .b    (b_sl),
        .cn   (carry_q),
        .f    (sl_f),
        .cn_4 (sl_cn4),
        .p    (sl_p),
        .g    (sl_g)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .c_msb(sl_cmsb)
`endif
    );

    // Control FSM and all registered datapath outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            k_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b1;
            pacc_q  <= 1'b1;
            gacc_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            f       <= '0;
            cn_out  <= 1'b1;
            a_eq_b  <= 1'b0;
            p       <= 1'b1;
            g       <= 1'b1;
`ifdef ALU_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        s_q     <= s;
                        m_q     <= m;
                        carry_q <= cn;
                        a_q     <= a;
                        b_q     <= b;
                        k_q     <= '0;
                        pacc_q  <= 1'b1;
                        gacc_q  <= 1'b0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    f       <= f_next;
                    carry_q <= sl_cn4;
                    cn_out  <= sl_cn4;
                    pacc_q  <= pacc_next;
                    gacc_q  <= gacc_next;
                    k_q     <= k_q + 1'b1;
                    if (last) begin
                        a_eq_b  <= &f_next;
                        p       <= ~pacc_next;
                        g       <= ~gacc_next;
`ifdef ALU_SERIAL_OVF_EN
                        // Carry into MSB vs carry out of MSB (both active-high here)
                        ovf     <= m_q ? 1'b0 : (sl_cmsb ^ ~sl_cn4);
`endif
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
